// File: rtl/cfg_lut_gate_pkg.sv
// Shared types for the configurable LUT gate: FSM state encoding and bit-counter sizing.
package cfg_lut_gate_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   // Counter must reach nbits itself, hence the +1.
   function automatic int unsigned cnt_width(input int unsigned nbits);
      return $clog2(nbits + 1);
   endfunction

endpackage

// File: rtl/cfg_lut_gate_lut_channel.sv
// One logic channel: selects one bit of its truth-table slice by the K-bit index.
module lut_channel #(
   parameter int unsigned K = 3
) (
   input  logic [(1<<K)-1:0] tbl,
   input  logic [K-1:0]      idx,
   output logic              o
);

   assign o = tbl[idx];

endmodule

// File: rtl/cfg_lut_gate.sv
// Serially configured CH-channel, K-input LUT gate with load FSM and optional output register.
module cfg_lut_gate
   import cfg_lut_gate_pkg::*;
#(
   parameter int unsigned K       = 3,
   parameter int unsigned CH      = 2,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_busy,
   output logic            cfg_done,
   input  logic [CH*K-1:0] x,
   input  logic            en,
   output logic [CH-1:0]   y,
   output logic            y_valid
);

   localparam int unsigned TW    = 1 << K;
   localparam int unsigned NBITS = CH * TW;
   localparam int unsigned CW    = cnt_width(NBITS);

   state_t            state;
   logic [NBITS-1:0]  tbl;
   logic [CW-1:0]     cnt;
   logic [CH-1:0]     lut_y;
   logic [CH-1:0]     y_r;
   logic              y_valid_r;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      lut_channel #(.K(K)) u_ch (
         .tbl (tbl[c*TW +: TW]),
         .idx (x[c*K +: K]),
         .o   (lut_y[c])
      );
   end

   // Load FSM, shift register, bit counter and registered result path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tbl       <= '0;
         cnt       <= '0;
         y_r       <= '0;
         y_valid_r <= 1'b0;
         cfg_done  <= 1'b0;
      end else begin
         cfg_done  <= 1'b0;
         y_valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  state <= S_LOAD;
                  cnt   <= '0;
               end
            end
            S_LOAD: begin
               if (cfg_valid) begin
                  tbl <= {cfg_bit, tbl[NBITS-1:1]};
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(NBITS - 1)) begin
                     state    <= S_DONE;
                     cfg_done <= 1'b1;
                  end
               end
            end
            S_DONE: state <= S_RUN;
            S_RUN: begin
               // A reload request pre-empts any evaluation in the same cycle.
               if (cfg_start) begin
                  state <= S_LOAD;
                  cnt   <= '0;
               end else if (en) begin
                  y_r       <= lut_y;
                  y_valid_r <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cfg_busy = (state == S_LOAD);

   if (REG_OUT) begin : g_reg
      assign y       = y_r;
      assign y_valid = y_valid_r;
   end else begin : g_comb
      assign y       = (state == S_RUN) ? lut_y : '0;
      assign y_valid = (state == S_RUN) & en;
   end

endmodule

// File: tb/tb_cfg_lut_gate.sv
// Scoreboard bench for cfg_lut_gate (K=3, CH=2) with registered and combinational instances.
module tb_cfg_lut_gate;

   logic       clk = 1'b0;
   logic       rst, cfg_start, cfg_valid, cfg_bit, en;
   logic [5:0] x;
   logic       cfg_busy, cfg_done, y_valid;
   logic [1:0] y;
   logic       cfg_busy2, cfg_done2, y_valid2;
   logic [1:0] y2;

   cfg_lut_gate #(.K(3), .CH(2), .REG_OUT(1'b1)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .x(x), .en(en), .y(y), .y_valid(y_valid));

   cfg_lut_gate #(.K(3), .CH(2), .REG_OUT(1'b0)) dut_c (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_busy(cfg_busy2), .cfg_done(cfg_done2), .x(x), .en(en), .y(y2), .y_valid(y_valid2));

   always #5 clk = ~clk;

   int         n_chk = 0, n_fail = 0;
   int         busy_cnt = 0, done_cnt = 0;
   bit         started = 1'b0;
   bit         running = 1'b0;
   logic [15:0] model_tbl = '0;
   logic [1:0]  last_y = '0;
   logic [1:0]  sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference lookup: channel c reads bit (c*8 + its 3-bit input) of the 16-bit table.
   function automatic logic [1:0] lookup(input logic [15:0] t, input logic [5:0] xv);
      logic [1:0] r;
      for (int c = 0; c < 2; c++) begin
         int idx;
         idx  = c * 8 + int'((xv >> (c * 3)) & 6'd7);
         r[c] = t[idx];
      end
      return r;
   endfunction

   // Monitor: pops an expected result whenever the registered DUT presents one.
   always @(negedge clk) begin
      if (started) begin
         if (cfg_busy) busy_cnt++;
         if (cfg_done) done_cnt++;
         check("y_hold", 32'(y), 32'(last_y));
         if (y_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_y_valid", 32'(y_valid), 32'd0);
            end else begin
               logic [1:0] e;
               e = sb.pop_front();
               check("sb_y", 32'(y), 32'(e));
            end
         end
         check("comb_y", 32'(y2), running ? 32'(lookup(model_tbl, x)) : 32'd0);
         check("comb_y_valid", 32'(y_valid2), running ? 32'(en) : 32'd0);
      end
   end

   task automatic eval_cycle(input logic [5:0] xv, input logic env, input logic nv, input logic nb);
      x = xv; en = env; cfg_valid = nv; cfg_bit = nb;
      @(posedge clk);
      if (running && env) begin
         logic [1:0] e;
         e = lookup(model_tbl, xv);
         sb.push_back(e);
         last_y = e;
      end
      #1;
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++)
         eval_cycle(6'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      eval_cycle(6'($urandom), 1'b0, 1'b0, 1'b0);
      eval_cycle(6'($urandom), 1'b0, 1'b0, 1'b0);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic sweep_all();
      for (int i = 0; i < 64; i++) eval_cycle(6'(i), 1'b1, 1'b0, 1'b0);
      eval_cycle(6'd0, 1'b0, 1'b0, 1'b0);
      eval_cycle(6'd0, 1'b0, 1'b0, 1'b0);
      check("sweep_drained", 32'(sb.size()), 32'd0);
   endtask

   // Serial load: start, one idle LOAD cycle, then 16 bits LSB first (optionally every other cycle).
   task automatic do_load(input logic [15:0] val, input bit stall, input bit with_en, input int abort_after);
      busy_cnt = 0; done_cnt = 0;
      cfg_start = 1'b1; en = with_en; cfg_valid = 1'b0; x = 6'($urandom);
      @(posedge clk);
      running = 1'b0;
      #1;
      cfg_start = 1'b0; en = 1'b0;
      @(negedge clk);
      check("load_busy", 32'(cfg_busy), 32'd1);
      check("load_y_valid", 32'(y_valid), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         if (i == abort_after) begin
            rst = 1'b1; cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
            @(posedge clk);
            last_y = '0;
            #1;
            rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(cfg_busy), 32'd0);
            check("abort_no_done", 32'(done_cnt), 32'd0);
            @(posedge clk); #1;
            return;
         end
         cfg_valid = 1'b1; cfg_bit = val[i];
         cfg_start = 1'($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         if (stall && i < 15) begin
            cfg_valid = 1'b0; cfg_bit = 1'($urandom);
            cfg_start = 1'($urandom);
            @(posedge clk); #1;
         end
      end
      cfg_start = 1'b0; cfg_valid = 1'($urandom); cfg_bit = 1'($urandom);
      @(negedge clk);
      check("done_pulse", 32'(cfg_done), 32'd1);
      check("done_busy", 32'(cfg_busy), 32'd0);
      @(posedge clk);
      running = 1'b1; model_tbl = val;
      #1;
      cfg_valid = 1'b0;
      check("busy_cycles", 32'(busy_cnt), stall ? 32'd32 : 32'd17);
      check("done_count", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; en = 1'b0; x = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; started = 1'b1;

      // Idle after reset: quiet outputs, no done pulse.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_y", 32'(y), 32'd0);
         check("idle_y_valid", 32'(y_valid), 32'd0);
         check("idle_busy", 32'(cfg_busy), 32'd0);
         check("idle_done", 32'(cfg_done), 32'd0);
      end
      check("idle_done_count", 32'(done_cnt), 32'd0);
      @(posedge clk); #1;

      do_load(16'h96E8, 1'b0, 1'b0, -1);
      eval_cycle({3'b111, 3'b011}, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("dir_y_11", 32'(y), 32'd3);
      check("dir_valid_11", 32'(y_valid), 32'd1);
      #1;
      eval_cycle({3'b110, 3'b001}, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("dir_y_00", 32'(y), 32'd0);
      check("dir_valid_00", 32'(y_valid), 32'd1);
      #1;
      run_random(30);

      do_load(16'h96E8, 1'b1, 1'b0, -1);
      sweep_all();

      do_load(16'hA5C3, 1'b0, 1'b0, 9);
      do_load(16'h00FF, 1'b0, 1'b0, -1);
      sweep_all();
      run_random(20);

      do_load(16'hFF00, 1'b0, 1'b1, -1);
      sweep_all();

      do_load(16'($urandom), 1'($urandom), 1'b1, -1);
      run_random(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
